// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      MC_WAIT = 2'b01,
      ERR     = 2'b10
   } hz_state_t;

   localparam int MC_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - per-operand forwarding source selector (youngest producer wins)
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] rs,
   input  logic             use_rs,
   input  logic [REG_W-1:0] rw_ex,
   input  logic [REG_W-1:0] rw_mem,
   input  logic [REG_W-1:0] rw_wb,
   input  logic             wr_en_ex,
   input  logic             wr_en_mem,
   input  logic             wr_en_wb,
   input  logic             load_ex,
   output fwd_sel_t         sel
);

   always_comb begin
      sel = FWD_RF;
      if (use_rs) begin
         // A load in EX has no data yet; the load-use stall covers that case.
         if (wr_en_ex && !load_ex && (rw_ex == rs)) begin
            sel = FWD_EX;
         end else if (wr_en_mem && (rw_mem == rs)) begin
            sel = FWD_MEM;
         end else if (wr_en_wb && (rw_wb == rs)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard controller: forwarding, branch/load-use control, multi-cycle EX wait
// Optional saturating performance counters when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_W      = 5,
   parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] ra_id,
   input  logic [REG_W-1:0] rb_id,
   input  logic             use_ra,
   input  logic             use_rb,
   input  logic [REG_W-1:0] rw_ex,
   input  logic [REG_W-1:0] rw_mem,
   input  logic [REG_W-1:0] rw_wb,
   input  logic             wr_en_ex,
   input  logic             wr_en_mem,
   input  logic             wr_en_wb,
   input  logic             load_ex,
   input  logic             branch_taken,
   input  logic             mc_start,
   input  logic             mc_done,
   output logic [1:0]       forward_ra,
   output logic [1:0]       forward_rb,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             mc_error
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] fwd_cnt
`endif
);

   localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

   hz_state_t         state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              active_q, active_d;
   fwd_sel_t          fwd_a, fwd_b;
   logic              load_use;

   fwd_sel #(.REG_W(REG_W)) u_fwd_a (
      .rs        (ra_id),
      .use_rs    (use_ra),
      .rw_ex     (rw_ex),
      .rw_mem    (rw_mem),
      .rw_wb     (rw_wb),
      .wr_en_ex  (wr_en_ex),
      .wr_en_mem (wr_en_mem),
      .wr_en_wb  (wr_en_wb),
      .load_ex   (load_ex),
      .sel       (fwd_a)
   );

   fwd_sel #(.REG_W(REG_W)) u_fwd_b (
      .rs        (rb_id),
      .use_rs    (use_rb),
      .rw_ex     (rw_ex),
      .rw_mem    (rw_mem),
      .rw_wb     (rw_wb),
      .wr_en_ex  (wr_en_ex),
      .wr_en_mem (wr_en_mem),
      .wr_en_wb  (wr_en_wb),
      .load_ex   (load_ex),
      .sel       (fwd_b)
   );

   assign load_use = load_ex & wr_en_ex &
                     ((use_ra & (ra_id == rw_ex)) | (use_rb & (rb_id == rw_ex)));

   // active_q keeps every output quiet for the first cycle after reset release.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      active_d   = 1'b1;
      forward_ra = FWD_RF;
      forward_rb = FWD_RF;
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      flush_id   = 1'b0;
      flush_ex   = 1'b0;
      mc_error   = 1'b0;
      if (active_q) begin
         forward_ra = fwd_a;
         forward_rb = fwd_b;
         case (state_q)
            RUN: begin
               if (mc_start) begin
                  if (!mc_done) begin
                     state_d    = MC_WAIT;
                     wait_cnt_d = '0;
                  end
               end else if (branch_taken) begin
                  flush_id = 1'b1;
                  flush_ex = 1'b1;
               end else if (load_use) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
                  flush_ex = 1'b1;
               end
            end
            MC_WAIT: begin
               stall_if   = 1'b1;
               stall_id   = 1'b1;
               stall_ex   = 1'b1;
               wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
               if (mc_done) begin
                  state_d = RUN;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_d = ERR;
               end
            end
            ERR: begin
               stall_if   = 1'b1;
               stall_id   = 1'b1;
               stall_ex   = 1'b1;
               mc_error   = 1'b1;
               wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         active_q   <= active_d;
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall_if && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_id && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (((|forward_ra) || (|forward_rb)) && !(&fwd_cnt_q)) begin
         fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed check of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

   localparam int REG_W      = 5;
   localparam int MC_TIMEOUT = 64;
   localparam int CNT_W      = 8;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [REG_W-1:0] ra_id, rb_id, rw_ex, rw_mem, rw_wb;
   logic             use_ra, use_rb, wr_en_ex, wr_en_mem, wr_en_wb;
   logic             load_ex, branch_taken, mc_start, mc_done;
   logic [1:0]       forward_ra, forward_rb;
   logic             stall_if, stall_id, stall_ex, flush_id, flush_ex, mc_error;
`ifdef HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt, fwd_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // model state: mode 0=running, 1=waiting on multi-cycle unit, 2=timed out
   int m_mode   = 0;
   int m_waited = 0;
   bit m_live   = 0;
   int m_stall  = 0;
   int m_flush  = 0;
   int m_fwd    = 0;

   logic [1:0] e_fa, e_fb;
   logic       e_sif, e_sid, e_sex, e_fid, e_fex, e_err;

   always #5 clock = ~clock;

   hazard_ctrl #(.REG_W(REG_W), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .ra_id        (ra_id),
      .rb_id        (rb_id),
      .use_ra       (use_ra),
      .use_rb       (use_rb),
      .rw_ex        (rw_ex),
      .rw_mem       (rw_mem),
      .rw_wb        (rw_wb),
      .wr_en_ex     (wr_en_ex),
      .wr_en_mem    (wr_en_mem),
      .wr_en_wb     (wr_en_wb),
      .load_ex      (load_ex),
      .branch_taken (branch_taken),
      .mc_start     (mc_start),
      .mc_done      (mc_done),
      .forward_ra   (forward_ra),
      .forward_rb   (forward_rb),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .stall_ex     (stall_ex),
      .flush_id     (flush_id),
      .flush_ex     (flush_ex),
      .mc_error     (mc_error)
`ifdef HAZARD_CTRL_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .fwd_cnt      (fwd_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Scan producers youngest to oldest; first one writing rs supplies the operand.
   function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] rs, input logic used);
      logic [REG_W-1:0] dst [3];
      logic             wr  [3];
      dst[0] = rw_ex;  wr[0] = wr_en_ex & ~load_ex;
      dst[1] = rw_mem; wr[1] = wr_en_mem;
      dst[2] = rw_wb;  wr[2] = wr_en_wb;
      if (!used) return 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (wr[k] && dst[k] == rs) return 2'(k + 1);
      end
      return 2'd0;
   endfunction

   task automatic compute_exp();
      {e_fa, e_fb, e_sif, e_sid, e_sex, e_fid, e_fex, e_err} = '0;
      if (reset && m_live) begin
         e_fa = exp_fwd(ra_id, use_ra);
         e_fb = exp_fwd(rb_id, use_rb);
         if (m_mode != 0) begin
            e_sif = 1; e_sid = 1; e_sex = 1;
            e_err = (m_mode == 2);
         end else if (mc_start) begin
            e_sif = 0;
         end else if (branch_taken) begin
            e_fid = 1; e_fex = 1;
         end else if (load_ex && wr_en_ex &&
                      ((use_ra && ra_id == rw_ex) || (use_rb && rb_id == rw_ex))) begin
            e_sif = 1; e_sid = 1; e_fex = 1;
         end
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_waited = 0; m_live = 0;
      m_stall = 0; m_flush = 0; m_fwd = 0;
   endtask

   task automatic sample();
      @(negedge clock);
      compute_exp();
      chk("forward_ra", forward_ra, e_fa);
      chk("forward_rb", forward_rb, e_fb);
      chk("stall_if", stall_if, e_sif);
      chk("stall_id", stall_id, e_sid);
      chk("stall_ex", stall_ex, e_sex);
      chk("flush_id", flush_id, e_fid);
      chk("flush_ex", flush_ex, e_fex);
      chk("mc_error", mc_error, e_err);
`ifdef HAZARD_CTRL_PERF_EN
      chk("stall_cnt", stall_cnt, (m_stall > CNT_MAX) ? CNT_MAX : m_stall);
      chk("flush_cnt", flush_cnt, (m_flush > CNT_MAX) ? CNT_MAX : m_flush);
      chk("fwd_cnt", fwd_cnt, (m_fwd > CNT_MAX) ? CNT_MAX : m_fwd);
`endif
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) begin
         if (m_live) begin
            m_stall += int'(e_sif);
            m_flush += int'(e_fid);
            m_fwd   += int'((e_fa != 0) || (e_fb != 0));
         end
         if (!m_live) begin
            m_live = 1;
         end else if (m_mode == 0) begin
            if (mc_start && !mc_done) begin
               m_mode = 1; m_waited = 0;
            end
         end else if (m_mode == 1) begin
            if (mc_done) begin
               m_mode = 0;
            end else begin
               m_waited++;
               if (m_waited >= MC_TIMEOUT) m_mode = 2;
            end
         end
      end
      #1;
   endtask

   task automatic step();
      sample();
      tick();
   endtask

   task automatic clear_in();
      {ra_id, rb_id, rw_ex, rw_mem, rw_wb} = '0;
      {use_ra, use_rb, wr_en_ex, wr_en_mem, wr_en_wb} = '0;
      {load_ex, branch_taken, mc_start, mc_done} = '0;
   endtask

   task automatic do_reset();
      reset = 0;
      model_reset();
      repeat (2) step();
      reset = 1;
      step();
   endtask

   task automatic rand_in();
      ra_id = REG_W'($urandom_range(0, 3));
      rb_id = REG_W'($urandom_range(0, 3));
      rw_ex = REG_W'($urandom_range(0, 3));
      rw_mem = REG_W'($urandom_range(0, 3));
      rw_wb = REG_W'($urandom_range(0, 3));
      use_ra = ($urandom_range(0, 3) != 0);
      use_rb = ($urandom_range(0, 3) != 0);
      wr_en_ex = ($urandom_range(0, 3) != 0);
      wr_en_mem = ($urandom_range(0, 3) != 0);
      wr_en_wb = ($urandom_range(0, 3) != 0);
      load_ex = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      mc_start = ($urandom_range(0, 19) == 0);
      mc_done = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      // outputs must stay low in reset and in the first cycle after release
      clear_in();
      ra_id = 2; use_ra = 1; rw_ex = 2; wr_en_ex = 1; branch_taken = 1; mc_start = 1;
      repeat (2) step();
      reset = 1;
      sample();
      chk("first_cycle_flush_id", flush_id, 0);
      chk("first_cycle_fwd_a", forward_ra, 0);
      tick();

      clear_in();
      rw_ex = 1; wr_en_ex = 1; ra_id = 1; use_ra = 1;
      sample();
      chk("b2b_fwd_a", forward_ra, 2'b01);
      chk("b2b_no_stall", stall_if, 0);
      tick();

      clear_in();
      rb_id = 3; use_rb = 1; rw_ex = 3; rw_mem = 3; rw_wb = 3;
      wr_en_ex = 1; wr_en_mem = 1; wr_en_wb = 1;
      sample(); chk("tri_ex", forward_rb, 2'b01); tick();
      wr_en_ex = 0;
      sample(); chk("tri_mem", forward_rb, 2'b10); tick();
      wr_en_mem = 0;
      sample(); chk("tri_wb", forward_rb, 2'b11); tick();

      do_reset();
      clear_in();
      load_ex = 1; wr_en_ex = 1; rw_ex = 5; rb_id = 5; use_rb = 1;
      sample();
      chk("lu_stall_if", stall_if, 1);
      chk("lu_stall_id", stall_id, 1);
      chk("lu_flush_ex", flush_ex, 1);
      chk("lu_stall_ex", stall_ex, 0);
      tick();
      load_ex = 0; wr_en_ex = 0; rw_ex = 0; rw_mem = 5; wr_en_mem = 1;
      sample(); chk("lu_fwd_mem", forward_rb, 2'b10); chk("lu_released", stall_if, 0); tick();

      clear_in();
      branch_taken = 1; load_ex = 1; wr_en_ex = 1; rw_ex = 7; ra_id = 7; use_ra = 1;
      sample();
      chk("br_flush_id", flush_id, 1);
      chk("br_flush_ex", flush_ex, 1);
      chk("br_no_stall", stall_if, 0);
      tick();
      clear_in();
`ifdef HAZARD_CTRL_PERF_EN
      sample();
      chk("perf_stall_1", stall_cnt, 1);
      chk("perf_flush_1", flush_cnt, 1);
      tick();
`endif

      // multi-cycle op completing after five cycles
      mc_start = 1;
      sample(); chk("mc_start_no_stall", stall_if, 0); tick();
      mc_start = 0;
      for (int i = 1; i <= 4; i++) begin
         sample(); chk("mc_wait_stall", stall_ex, 1); tick();
      end
      mc_done = 1;
      sample(); chk("mc_done_cycle_stall", stall_if, 1); tick();
      mc_done = 0;
      sample(); chk("mc_after_done", stall_if, 0); tick();

      // timeout, stickiness, and asynchronous reset out of ERR
      mc_start = 1; step(); mc_start = 0;
      repeat (MC_TIMEOUT) step();
      sample(); chk("timeout_err", mc_error, 1); tick();
      mc_done = 1;
      repeat (3) step();
      sample(); chk("err_sticky", mc_error, 1);
      #2 reset = 0;
      model_reset();
      #1;
      chk("async_rst_err", mc_error, 0);
      chk("async_rst_stall", stall_if, 0);
      tick();
      clear_in();
      step();
      reset = 1;
      step();

      // asynchronous reset in the middle of a wait
      mc_start = 1; step(); mc_start = 0;
      repeat (10) step();
      sample();
      #2 reset = 0;
      model_reset();
      #1;
      chk("midwait_rst_stall", stall_ex, 0);
      tick();
      step();
      reset = 1;
      step();
      sample(); chk("midwait_run", stall_if, 0); tick();

      for (int i = 0; i < 1500; i++) begin
         rand_in();
         if (i % 400 == 399) do_reset();
         else step();
      end

      clear_in();
      mc_start = 1; step(); mc_start = 0;
      repeat (MC_TIMEOUT + CNT_MAX + 10) step();
`ifdef HAZARD_CTRL_PERF_EN
      sample(); chk("perf_stall_sat", stall_cnt, CNT_MAX); tick();
`endif
      sample(); chk("long_err", mc_error, 1); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
